// File: rtl/sync_filter.sv
// sync_filter: multi-channel input synchronizer with glitch filter
// and one-cycle rise/fall pulses on the filtered level.
module sync_filter #(
  parameter int               WIDTH      = 8,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
  parameter int               FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  input  logic             filt_en,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] filt_nxt;
  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  // Only stage 0 touches async_in; no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++)
        chain[s] <= RST_VAL;
    end else begin
      chain[0] <= async_in;
      for (int s = 1; s < STAGES; s++)
        chain[s] <= chain[s-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign diff     = sync_out ^ filt_out;

  always_comb begin
    filt_nxt = filt_out;
    for (int c = 0; c < WIDTH; c++) begin
      cnt_nxt[c] = cnt[c];
      unique case (1'b1)
        !filt_en: begin
          filt_nxt[c] = sync_out[c];
          cnt_nxt[c]  = '0;
        end
        filt_en && !diff[c]: begin
          cnt_nxt[c] = '0;
        end
        filt_en && diff[c] && (cnt[c] == LAST): begin
          filt_nxt[c] = sync_out[c];
          cnt_nxt[c]  = '0;
        end
        default: begin
          cnt_nxt[c] = cnt[c] + CW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_out <= RST_VAL;
      filt_d   <= RST_VAL;
      for (int c = 0; c < WIDTH; c++)
        cnt[c] <= '0;
    end else begin
      filt_out <= filt_nxt;
      filt_d   <= filt_out;
      for (int c = 0; c < WIDTH; c++)
        cnt[c] <= cnt_nxt[c];
    end
  end

  assign rise = filt_out & ~filt_d;
  assign fall = ~filt_out & filt_d;

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed scenarios plus random traffic, all
// outputs compared every cycle against a run-length reference model.
module tb_sync_filter;

  localparam int         ST = 2;
  localparam int         FL = 4;
  localparam logic [3:0] RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       filt_en = 1'b1;
  logic [3:0] async_in = 4'hF;
  logic [3:0] sync_out;
  logic [3:0] filt_out;
  logic [3:0] rise;
  logic [3:0] fall;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  sync_filter #(
    .WIDTH(4),
    .STAGES(ST),
    .RST_VAL(RV),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .async_in(async_in),
    .filt_en(filt_en),
    .sync_out(sync_out),
    .filt_out(filt_out),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference: sampled inputs delayed STAGES edges; filtered level
  // flips once the synced value has disagreed for FL edges in a row.
  logic [3:0] sq [$];
  logic [3:0] m_filt;
  logic [3:0] m_prev;
  logic [3:0] m_sync;
  logic [3:0] m_nxt;
  int         streak [4];

  function automatic void m_reset();
    sq = {};
    for (int k = 0; k < ST; k++) sq.push_front(RV);
    m_filt = RV;
    m_prev = RV;
    for (int c = 0; c < 4; c++) streak[c] = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      m_sync = sq[ST-1];
      m_nxt = m_filt;
      for (int c = 0; c < 4; c++) begin
        if (!filt_en) begin
          m_nxt[c] = m_sync[c];
          streak[c] = 0;
        end else if (m_sync[c] == m_filt[c]) begin
          streak[c] = 0;
        end else begin
          streak[c]++;
          if (streak[c] == FL) begin
            m_nxt[c] = m_sync[c];
            streak[c] = 0;
          end
        end
      end
      m_prev = m_filt;
      m_filt = m_nxt;
      sq.push_front(async_in);
      void'(sq.pop_back());
    end
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    if (armed) begin
      chk("m_sync", sync_out, sq[ST-1]);
      chk("m_filt", filt_out, m_filt);
      chk("m_rise", rise, m_filt & ~m_prev);
      chk("m_fall", fall, ~m_filt & m_prev);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  int nr;
  int nf;

  initial begin
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      armed = 1;
      chk("rst_sync", sync_out, 4'h5);
      chk("rst_filt", filt_out, 4'h5);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
    end
    async_in = 4'b0101;
    rst = 1'b0;
    tick();
    chk("rel_rise", rise, 4'h0);
    chk("rel_fall", fall, 4'h0);
    repeat (4) tick();

    // step on channel 1
    async_in = 4'b0111;
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk("step_sync", sync_out, (i >= 1) ? 4'b0111 : 4'b0101);
      chk("step_filt", filt_out, (i >= 5) ? 4'b0111 : 4'b0101);
      chk("step_rise", rise, (i == 5) ? 4'b0010 : 4'b0000);
      chk("step_fall", fall, 4'h0);
    end

    // 3-cycle glitch on channel 3 is swallowed
    async_in = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) async_in = 4'b0111;
      chk("glitch_filt3", {3'b0, filt_out[3]}, 4'h0);
      chk("glitch_rise3", {3'b0, rise[3]}, 4'h0);
    end

    // 4-cycle pulse on channel 3 passes
    nr = 0;
    nf = 0;
    async_in = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 3) async_in = 4'b0111;
      nr += int'(rise[3]);
      nf += int'(fall[3]);
      if (i == 5) chk("pulse_hi", filt_out, 4'b1111);
      if (i == 8) chk("pulse_hold", filt_out, 4'b1111);
      if (i == 9) chk("pulse_lo", filt_out, 4'b0111);
    end
    chk("pulse_nrise", 4'(nr), 4'd1);
    chk("pulse_nfall", 4'(nf), 4'd1);

    // bypass
    filt_en = 1'b0;
    repeat (2) tick();
    async_in = 4'b0110;
    for (int i = 0; i <= 3; i++) begin
      tick();
      chk("byp_sync", sync_out, (i >= 1) ? 4'b0110 : 4'b0111);
      chk("byp_filt", filt_out, (i >= 2) ? 4'b0110 : 4'b0111);
      chk("byp_fall", fall, (i == 2) ? 4'b0001 : 4'b0000);
    end

    // drop filt_en while channel 2 is mid-count
    filt_en = 1'b1;
    repeat (2) tick();
    async_in = 4'b0010;
    for (int i = 0; i <= 3; i++) tick();
    chk("midcnt_hold", filt_out, 4'b0110);
    filt_en = 1'b0;
    tick();
    chk("midcnt_filt", filt_out, 4'b0010);
    chk("midcnt_fall", fall, 4'b0100);
    filt_en = 1'b1;
    repeat (3) tick();

    // all channels at once
    async_in = 4'b0101;
    repeat (8) tick();
    async_in = 4'b1010;
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk("sim_filt", filt_out, (i >= 5) ? 4'hA : 4'h5);
      chk("sim_rise", rise, (i == 5) ? 4'hA : 4'h0);
      chk("sim_fall", fall, (i == 5) ? 4'h5 : 4'h0);
    end

    // reset in the middle of a count
    async_in = 4'b1000;
    for (int i = 0; i <= 3; i++) tick();
    rst = 1'b1;
    #1;
    chk("arst_sync", sync_out, 4'h5);
    chk("arst_filt", filt_out, 4'h5);
    chk("arst_rise", rise, 4'h0);
    chk("arst_fall", fall, 4'h0);
    async_in = 4'b0111;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("rrel_sync", sync_out, (i >= 2) ? 4'b0111 : 4'b0101);
      chk("rrel_filt", filt_out, (i >= 6) ? 4'b0111 : 4'b0101);
      chk("rrel_rise", rise, (i == 6) ? 4'b0010 : 4'b0000);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) async_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) filt_en = ~filt_en;
    end
    rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
